dma_reader: RTL and testbench
=============================

DMA_READER -- requirements
Module: dma_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, output buffer depth in 64-bit words; power of two, at least 16.
REQ-002 SHALL have parameter BURST_BEATS, default 16, beats per AXI3 read burst; fixed.
REQ-003 SHALL have port aclk, input, 1: clock, all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port m_axi_araddr, output, 32: burst start address.
REQ-006 SHALL have port m_axi_arvalid / m_axi_arready, output / input, 1 each: read-address handshake.
REQ-007 SHALL have port m_axi_arlen / arsize / arburst, output, 4 / 3 / 2: constant 4'd15, 3'd3, 2'b01 (INCR).
REQ-008 SHALL have port m_axi_rdata, input, 64: read beat data.
REQ-009 SHALL have port m_axi_rvalid / m_axi_rready, input / output, 1 each: read-data handshake.
REQ-010 SHALL have port m_axi_rresp / m_axi_rlast, input, 2 / 1: beat response, last beat.
REQ-011 SHALL have port start_i, input, 1: level; a rising edge starts a transfer.
REQ-012 SHALL have port base_addr_i, input, 32: first burst address; must be 128-byte aligned.
REQ-013 SHALL have port num_bursts_i, input, 16: burst count.
REQ-014 SHALL have port m_data_o / m_valid_o / m_ready_i, output / output / input, 64 / 1 / 1: sample stream.
REQ-015 SHALL have ports busy_o, done_o and error_o, output, 1 each: status.

Function
REQ-016 SHALL register start_i once and detect the rising edge; edges arriving outside IDLE and DONE are ignored.
REQ-017 SHALL latch base_addr_i and num_bursts_i on the accepted edge.
REQ-018 SHALL implement states IDLE, ADDR, DATA and DONE.
REQ-019 On edge, IDLE or DONE SHALL go to ADDR; if num_bursts_i == 0 it SHALL go to DONE instead.
REQ-020 ADDR SHALL assert arvalid only when FIFO free slots >= 16; araddr = current address, held stable until arready.
REQ-021 ADDR SHALL go to DATA on the arvalid&&arready cycle.
REQ-022 Only one burst SHALL be outstanding at a time.
REQ-023 DATA SHALL hold rready=1 and push rdata into the FIFO on each rvalid beat, counting beats 0..15 in 5 bits.
REQ-024 On the handshake of beat 15, the address SHALL advance by 128 and the remaining-burst count SHALL decrement.
REQ-025 After beat 15, DATA SHALL go to DONE if the remaining count reaches 0, otherwise to ADDR.
REQ-026 A beat with rresp != 2'b00, or with rlast != (beat == 15), SHALL set error_o sticky.
REQ-027 Erroneous data SHALL still be pushed, and no retry SHALL occur.
REQ-028 error_o SHALL clear on the next accepted start edge.
REQ-029 The FIFO SHALL be show-ahead: m_valid_o = !empty and m_data_o = head word; pop on m_valid_o&&m_ready_i.
REQ-030 The FIFO SHALL accept a simultaneous push and pop in the same cycle, with count unchanged.
REQ-031 Pop when full SHALL be legal; push when full is unreachable by the REQ-020 credit rule and SHALL be flagged by an assertion.
REQ-032 The first pushed word SHALL appear on m_data_o one cycle after its R handshake.
REQ-033 busy_o SHALL be 1 in ADDR and DATA.
REQ-034 done_o SHALL be 1 in DONE and held until the next accepted edge.
REQ-035 The FIFO SHALL NOT be flushed on start; it drains naturally.
REQ-036 The address SHALL wrap modulo 2^32 without error.

Reset
REQ-037 Asserting rst_i SHALL clear: state IDLE; arvalid, rready, busy_o, done_o, error_o, m_valid_o = 0; araddr = 0; m_data_o = 0.
REQ-038 Reset SHALL also empty the FIFO and clear the beat and burst counters.
REQ-039 Reset mid-burst SHALL abandon the AXI transaction without draining it; it is a system-level reset only.

Structure
REQ-040 A shared package SHALL hold the AXI constants (BURST_LEN 4'd15, BEAT_SIZE 3'd3, BURST_INC 2'b01, RESP_OKAY 2'b00), the 128-byte address increment and the state enum.
REQ-041 The package SHALL be shared with the DMA write controller.
REQ-042 The design SHALL have one sub-module, sync_fifo (parameterised width/depth, count output), instantiated once.

Verification
REQ-043 Scenario: base 0x1000_0000, num_bursts 3, m_ready_i=1, slave arready=1 and rvalid=1 continuously -> araddr 0x1000_0000, 0x1000_0080 and 0x1000_0100; 48 words out in order; then done_o=1 and error_o=0.
REQ-044 Scenario: m_ready_i=0, num_bursts 4, FIFO_DEPTH 32 -> exactly 2 bursts issued, arvalid stays 0 with 32 words buffered; raising m_ready_i resumes with the third burst after free slots >= 16.
REQ-045 Scenario: rresp=2'b10 on beat 7 of burst 1 -> error_o=1, all 16 words still delivered, next burst issued, error_o cleared by the next start edge.
REQ-046 Scenario: num_bursts 0 -> done_o=1 two cycles after the start_i rise, no arvalid.
REQ-047 Scenario: rst_i asserted during DATA beat 5 -> all outputs at reset values immediately, FIFO empty; a fresh start then works normally.
REQ-048 Scenario: start_i pulsed again while busy -> ignored; burst count and addresses are unaffected.

Source files
------------

// File: rtl/dma_reader_pkg.sv
// Shared AXI3 read/write DMA constants and the controller state encoding.
// Used by both the DMA reader and the DMA write controller.
package dma_reader_pkg;

  localparam logic [3:0]  BURST_LEN      = 4'd15;
  localparam logic [2:0]  BEAT_SIZE      = 3'd3;
  localparam logic [1:0]  BURST_INC      = 2'b01;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [31:0] BURST_ADDR_INC = 32'd128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } dma_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; head word is visible
// on o_data whenever the FIFO is non-empty, zero otherwise.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The reader's credit check keeps pushes away from a full buffer.
  assert property (@(posedge i_clk) disable iff (i_rst) !(i_push && w_full));

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/dma_reader.sv
// AXI3 burst reader: fetches num_bursts x 16-beat bursts from base_addr and
// streams the 64-bit beats out through a credit-guarded show-ahead FIFO.
module dma_reader
  import dma_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter int unsigned BURST_BEATS = 16
) (
  input  logic        aclk,
  input  logic        rst_i,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [3:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  input  logic [63:0] m_axi_rdata,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] num_bursts_i,
  output logic [63:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_e     r_state;
  dma_state_e     w_next;
  logic           r_start_q;
  logic           r_start_qq;
  logic [31:0]    r_addr;
  logic [15:0]    r_bursts;
  logic [4:0]     r_beat;
  logic           r_error;
  logic           w_accept;
  logic           w_ar_hs;
  logic           w_r_hs;
  logic           w_last_beat;
  logic           w_credit;
  logic           w_empty;
  logic [CW-1:0]  w_count;

  assign w_accept    = r_start_q && !r_start_qq &&
                       (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_ar_hs     = m_axi_arvalid && m_axi_arready;
  assign w_r_hs      = m_axi_rvalid && m_axi_rready;
  assign w_last_beat = (r_beat == 5'(BURST_LEN));
  assign w_credit    = (CW'(FIFO_DEPTH) - w_count) >= CW'(BURST_BEATS);

  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_accept) w_next = (num_bursts_i == '0) ? ST_DONE : ST_ADDR;
      ST_ADDR:          if (w_ar_hs)  w_next = ST_DATA;
      ST_DATA:          if (w_r_hs && w_last_beat)
                          w_next = (r_bursts == 16'd1) ? ST_DONE : ST_ADDR;
      default:          w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axi_arvalid = (r_state == ST_ADDR) && w_credit;
    m_axi_rready  = (r_state == ST_DATA);
    busy_o        = (r_state == ST_ADDR) || (r_state == ST_DATA);
    done_o        = (r_state == ST_DONE);
  end

  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      r_start_q  <= 1'b0;
      r_start_qq <= 1'b0;
      r_addr     <= '0;
      r_bursts   <= '0;
      r_beat     <= '0;
      r_error    <= 1'b0;
    end else begin
      r_start_q  <= start_i;
      r_start_qq <= r_start_q;
      if (w_accept) begin
        r_addr   <= base_addr_i;
        r_bursts <= num_bursts_i;
        r_beat   <= '0;
        r_error  <= 1'b0;
      end else if (w_r_hs) begin
        // Bad beats are flagged but still buffered; no retry is attempted.
        if (m_axi_rresp != RESP_OKAY || m_axi_rlast != w_last_beat)
          r_error <= 1'b1;
        if (w_last_beat) begin
          r_beat   <= '0;
          r_addr   <= r_addr + BURST_ADDR_INC;
          r_bursts <= r_bursts - 16'd1;
        end else begin
          r_beat   <= r_beat + 5'd1;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (aclk),
    .i_rst   (rst_i),
    .i_push  (w_r_hs),
    .i_data  (m_axi_rdata),
    .i_pop   (m_valid_o && m_ready_i),
    .o_data  (m_data_o),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign m_valid_o     = !w_empty;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = BURST_LEN;
  assign m_axi_arsize  = BEAT_SIZE;
  assign m_axi_arburst = BURST_INC;
  assign error_o       = r_error;

endmodule

// File: tb/tb_dma_reader.sv
// Directed bench for dma_reader: behavioural AXI3 read slave, stream sink
// monitor and per-scenario tasks with hand-derived expectations.
module tb_dma_reader;

  logic        aclk = 1'b0;
  logic        rst_i;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] num_bursts_i;
  logic [63:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] got[$];
  logic [31:0] aq[$];
  int          s_bidx;
  int          s_cur;
  int          s_beat;
  logic        s_active;
  logic [31:0] s_addr;
  int          err_burst = -1;

  dma_reader #(.FIFO_DEPTH(32), .BURST_BEATS(16)) dut (
    .aclk          (aclk),
    .rst_i         (rst_i),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .num_bursts_i  (num_bursts_i),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  always #5 aclk = ~aclk;

  // Slave: every beat carries {burst address, beat index}.
  initial begin
    logic        ar_hs;
    logic        r_hs;
    logic [31:0] sa;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    s_active = 1'b0; s_beat = 0; s_addr = '0; s_bidx = 0; s_cur = 0;
    forever begin
      @(negedge aclk); #2;
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      sa    = m_axi_araddr;
      @(posedge aclk); #1;
      if (r_hs) begin
        s_beat++;
        if (s_beat == 16) s_active = 1'b0;
      end
      if (ar_hs) begin
        aq.push_back(sa);
        s_active = 1'b1; s_beat = 0; s_addr = sa; s_cur = s_bidx; s_bidx++;
      end
      if (rst_i) begin
        s_active = 1'b0; s_beat = 0;
      end
      m_axi_rvalid = s_active;
      m_axi_rdata  = {s_addr, 32'(s_beat)};
      m_axi_rresp  = (s_active && s_cur == err_burst && s_beat == 7) ? 2'b10 : 2'b00;
      m_axi_rlast  = s_active && (s_beat == 15);
    end
  end

  initial begin
    forever begin
      @(negedge aclk); #2;
      if (m_valid_o && m_ready_i) got.push_back(m_data_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d words", got.size());
    $fatal(1);
  end

  function automatic logic [63:0] exp_word(input logic [31:0] base, input int i);
    return {base + 32'(128 * (i / 16)), 32'(i % 16)};
  endfunction

  task automatic clear_log();
    got.delete(); aq.delete(); s_bidx = 0;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] nb);
    @(negedge aclk); start_i = 1'b0;
    repeat (2) @(negedge aclk);
    base_addr_i = base; num_bursts_i = nb; start_i = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    repeat (3) @(negedge aclk);
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= n) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; m_ready_i = 1'b1;
    base_addr_i = '0; num_bursts_i = '0;
    repeat (2) @(negedge aclk);
    checks++;
    if ({m_axi_arvalid, m_axi_rready, busy_o, done_o, error_o, m_valid_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 000000",
        {m_axi_arvalid, m_axi_rready, busy_o, done_o, error_o, m_valid_o});
    end
    checks++;
    if (m_axi_araddr !== 32'h0 || m_data_o !== 64'h0) begin
      errors++; $display("FAIL reset_data: araddr %h data %h required 0", m_axi_araddr, m_data_o);
    end
    checks++;
    if ({m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {4'd15, 3'd3, 2'b01}) begin
      errors++; $display("FAIL ar_consts: got %h/%h/%h required f/3/1",
        m_axi_arlen, m_axi_arsize, m_axi_arburst);
    end
    @(negedge aclk); rst_i = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_zero_bursts();
    clear_log();
    do_start(32'h3000_0000, 16'd0);
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("FAIL zero_done_early: got %b required 0", done_o);
    end
    @(negedge aclk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL zero_done: done %b busy %b required 1 0", done_o, busy_o);
    end
    repeat (5) @(negedge aclk);
    checks++;
    if (aq.size() !== 0) begin
      errors++; $display("FAIL zero_no_ar: got %0d bursts required 0", aq.size());
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_log();
    do_start(32'h1000_0000, 16'd3);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got timeout required done_o=1"); end
    wait_words(48, 100, ok);
    checks++;
    if (got.size() !== 48) begin
      errors++; $display("FAIL basic_count: got %0d words required 48", got.size());
    end
    checks++;
    if (aq.size() !== 3 || aq[0] !== 32'h1000_0000 || aq[1] !== 32'h1000_0080 ||
        aq[2] !== 32'h1000_0100) begin
      errors++; $display("FAIL basic_addr: got %0d bursts first %h required 3 from 10000000",
        aq.size(), (aq.size() > 0) ? aq[0] : 32'h0);
    end
    for (int i = 0; i < got.size() && i < 48; i++) begin
      checks++;
      if (got[i] !== exp_word(32'h1000_0000, i)) begin
        errors++; $display("FAIL basic_word[%0d]: got %h required %h", i, got[i],
          exp_word(32'h1000_0000, i));
      end
    end
    checks++;
    if (done_o !== 1'b1 || error_o !== 1'b0) begin
      errors++; $display("FAIL basic_status: done %b error %b required 1 0", done_o, error_o);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_log();
    m_ready_i = 1'b0;
    do_start(32'h2000_0000, 16'd4);
    repeat (80) @(negedge aclk);
    checks++;
    if (aq.size() !== 2 || m_axi_arvalid !== 1'b0 || busy_o !== 1'b1 || m_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_stall: bursts %0d arvalid %b busy %b valid %b required 2 0 1 1",
        aq.size(), m_axi_arvalid, busy_o, m_valid_o);
    end
    @(negedge aclk); m_ready_i = 1'b1;
    repeat (15) @(negedge aclk);
    checks++;
    if (m_axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL bp_credit_15: arvalid %b required 0", m_axi_arvalid);
    end
    @(negedge aclk);
    checks++;
    if (m_axi_arvalid !== 1'b1) begin
      errors++; $display("FAIL bp_credit_16: arvalid %b required 1", m_axi_arvalid);
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done: got timeout required done_o=1"); end
    wait_words(64, 100, ok);
    checks++;
    if (got.size() !== 64 || aq.size() !== 4 || aq[2] !== 32'h2000_0100 ||
        aq[3] !== 32'h2000_0180) begin
      errors++; $display("FAIL bp_totals: words %0d bursts %0d required 64 4", got.size(), aq.size());
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      checks++;
      if (got[i] !== exp_word(32'h2000_0000, i)) begin
        errors++; $display("FAIL bp_word[%0d]: got %h required %h", i, got[i],
          exp_word(32'h2000_0000, i));
      end
    end
  endtask

  task automatic test_error();
    bit ok;
    clear_log();
    err_burst = 1;
    do_start(32'h4000_0000, 16'd3);
    wait_done(200, ok);
    wait_words(48, 100, ok);
    checks++;
    if (error_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky: error_o %b required 1", error_o);
    end
    checks++;
    if (got.size() !== 48 || aq.size() !== 3) begin
      errors++; $display("FAIL err_delivery: words %0d bursts %0d required 48 3", got.size(), aq.size());
    end
    for (int i = 16; i < 32 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_word(32'h4000_0000, i)) begin
        errors++; $display("FAIL err_word[%0d]: got %h required %h", i, got[i],
          exp_word(32'h4000_0000, i));
      end
    end
    err_burst = -1;
    do_start(32'h4000_1000, 16'd0);
    @(negedge aclk);
    checks++;
    if (error_o !== 1'b1) begin
      errors++; $display("FAIL err_hold: error_o %b required 1", error_o);
    end
    @(negedge aclk);
    checks++;
    if (error_o !== 1'b0 || done_o !== 1'b1) begin
      errors++; $display("FAIL err_clear: error %b done %b required 0 1", error_o, done_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    clear_log();
    do_start(32'h5000_0000, 16'd3);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (m_axi_rvalid && m_axi_rready && s_beat == 5) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_mid_reach: got timeout required beat 5"); end
    rst_i = 1'b1; start_i = 1'b0;
    #1;
    checks++;
    if ({m_axi_arvalid, m_axi_rready, busy_o, done_o, error_o, m_valid_o} !== 6'b0 ||
        m_axi_araddr !== 32'h0 || m_data_o !== 64'h0) begin
      errors++; $display("FAIL rst_mid_outputs: ctrl %b araddr %h data %h required 0",
        {m_axi_arvalid, m_axi_rready, busy_o, done_o, error_o, m_valid_o}, m_axi_araddr, m_data_o);
    end
    repeat (2) @(negedge aclk);
    rst_i = 1'b0;
    clear_log();
    do_start(32'h5000_0800, 16'd1);
    wait_done(200, ok);
    wait_words(16, 100, ok);
    checks++;
    if (got.size() !== 16 || aq.size() !== 1 || aq[0] !== 32'h5000_0800) begin
      errors++; $display("FAIL rst_restart: words %0d bursts %0d required 16 1", got.size(), aq.size());
    end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      checks++;
      if (got[i] !== exp_word(32'h5000_0800, i)) begin
        errors++; $display("FAIL rst_word[%0d]: got %h required %h", i, got[i],
          exp_word(32'h5000_0800, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    do_start(32'h6000_0000, 16'd2);
    repeat (6) @(negedge aclk);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL b2b_busy: busy %b required 1", busy_o);
    end
    start_i = 1'b0;
    repeat (2) @(negedge aclk);
    base_addr_i = 32'h7000_0000; num_bursts_i = 16'd5; start_i = 1'b1;
    wait_done(200, ok);
    wait_words(32, 100, ok);
    checks++;
    if (got.size() !== 32 || aq.size() !== 2 || aq[0] !== 32'h6000_0000 ||
        aq[1] !== 32'h6000_0080) begin
      errors++; $display("FAIL b2b_ignored: words %0d bursts %0d required 32 2", got.size(), aq.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_log();
    do_start(32'hFFFF_FF80, 16'd2);
    wait_done(200, ok);
    wait_words(32, 100, ok);
    checks++;
    if (aq.size() !== 2 || aq[0] !== 32'hFFFF_FF80 || aq[1] !== 32'h0000_0000 || error_o !== 1'b0) begin
      errors++; $display("FAIL wrap_addr: bursts %0d second %h error %b required 2 00000000 0",
        aq.size(), (aq.size() > 1) ? aq[1] : 32'hX, error_o);
    end
    for (int i = 0; i < got.size() && i < 32; i++) begin
      checks++;
      if (got[i] !== exp_word(32'hFFFF_FF80, i)) begin
        errors++; $display("FAIL wrap_word[%0d]: got %h required %h", i, got[i],
          exp_word(32'hFFFF_FF80, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_bursts();
    test_basic();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
